cmd_queue_mp: RTL
=================

CMD_QUEUE_MP -- requirements
Module: cmd_queue_mp

Interface
REQ-001 SHALL provide parameter WIDTH, default 248, command word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 16, queue entries; legal values are powers of two, 2..256.
REQ-003 SHALL provide parameter NPORTS, default 2, producer (write) port count; legal range 1..8.
REQ-004 SHALL use one clock and one reset; reset is asynchronous, active-low.
REQ-005 SHALL provide i_clk  input  1  clock, all state on rising edge.
REQ-006 SHALL provide i_rstn  input  1  asynchronous active-low reset.
REQ-007 SHALL provide i_valid  input  NPORTS  per-port write request.
REQ-008 SHALL provide i_data  input  NPORTS*WIDTH  per-port command; port p occupies bits [p*WIDTH +: WIDTH].
REQ-009 SHALL provide o_ack  output  NPORTS  per-port accept strobe, one-hot or zero.
REQ-010 SHALL provide i_read  input  1  consumer pop request.
REQ-011 SHALL provide o_data  output  WIDTH  head-of-queue command (first-word-fall-through).
REQ-012 SHALL provide o_fifo_full  output  1  count == DEPTH.
REQ-013 SHALL provide o_fifo_empty  output  1  count == 0.
REQ-014 SHALL provide o_count  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 SHALL provide o_busy  output  1  any i_valid high and not acked this cycle.

Function
REQ-016 Handshake SHALL be valid/ack: the producer holds i_valid and its i_data stable until it samples o_ack high; a transfer occurs at the rising edge where i_valid[p] and o_ack[p] are both high.
REQ-017 o_ack SHALL be combinational: o_ack[p] = grant[p] & !o_fifo_full; no port is acked while full, even if i_read is high the same cycle.
REQ-018 Arbiter SHALL be round-robin: search starts at port (last_grant+1) mod NPORTS, wrapping; first port with i_valid high wins.
REQ-019 last_grant SHALL update only on an accepted transfer; refused requests (queue full) do not move the pointer.
REQ-020 At most one command SHALL be written per cycle.
REQ-021 Accepted command SHALL be written at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap, log2(DEPTH) bits).
REQ-022 o_data SHALL show mem[rd_ptr] combinationally; value is don't-care when empty.
REQ-023 i_read with !o_fifo_empty SHALL advance rd_ptr modulo DEPTH at the edge; i_read while empty SHALL be ignored (no pointer or count change).
REQ-024 Simultaneous accepted write and valid read SHALL leave o_count unchanged; write-only +1, read-only -1.
REQ-025 Read and write in same cycle on an empty queue: write accepted, read ignored, count becomes 1.
REQ-026 o_fifo_full, o_fifo_empty SHALL be derived from registered o_count, valid in the same cycle as o_count.
REQ-027 o_busy SHALL equal |(i_valid & ~o_ack).
REQ-028 No X SHALL propagate to o_ack, o_count, flags from unrequested ports' i_data.

Reset
REQ-029 On i_rstn low (asynchronous, any cycle, including mid-transfer): wr_ptr=0, rd_ptr=0, o_count=0, o_fifo_empty=1, o_fifo_full=0, last_grant=NPORTS-1 (port 0 first priority).
REQ-030 o_ack SHALL be 0 while i_rstn is low; storage contents need not be reset.
REQ-031 Commands held in the queue at reset assertion SHALL be discarded; no write occurs on the edge where reset deasserts if i_rstn is sampled low.

Verification
REQ-032 Reset, no stimulus -> o_count=0, empty=1, full=0, o_ack=0, o_busy=0.
REQ-033 NPORTS=2, both valid continuously, data port0=0xA0.., port1=0xB0.., no reads -> acks alternate p0,p1,p0,...; after 16 cycles full=1, o_ack=0, o_busy=1; pop order A0,B0,A1,B1...
REQ-034 Full queue, i_read=1 and i_valid[0]=1 same cycle -> no ack that cycle, count 16->15; next cycle ack[0]=1, count stays 15 if read continues.
REQ-035 Empty queue, i_read=1 only -> count stays 0, pointers unchanged; then write 0x5 with read asserted -> count=1, o_data=0x5.
REQ-036 Write 40 commands through DEPTH=16 with interleaved reads -> data pops in order across pointer wrap, count never exceeds 16 or underflows.
REQ-037 Assert i_rstn low with count=7 and valid pending -> count=0, empty=1, o_ack=0 immediately; after release, port 0 granted first.

Source files
------------

// File: rtl/cmd_queue_mp.sv
// Purpose: multi-producer command queue; round-robin arbiter feeding one FWFT FIFO.
// Latency: an accepted command is visible on o_data the cycle after its ack edge.
// Backpressure: o_ack is withheld from every port while the queue is full; requests are held by producers.
module cmd_queue_mp #(
    parameter int WIDTH  = 248,
    parameter int DEPTH  = 16,
    parameter int NPORTS = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic [NPORTS-1:0]             i_valid,
    input  logic [NPORTS*WIDTH-1:0]       i_data,
    output logic [NPORTS-1:0]             o_ack,
    input  logic                          i_read,
    output logic [WIDTH-1:0]              o_data,
    output logic                          o_fifo_full,
    output logic                          o_fifo_empty,
    output logic [$clog2(DEPTH+1)-1:0]    o_count,
    output logic                          o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     grant_idx;
    logic [NPORTS-1:0] grant;
    logic [WIDTH-1:0]  wr_dat;
    logic              wr_en;
    logic              rd_en;

    // Round-robin search starting one past the last accepted port; first requester wins.
    always_comb begin
        logic          found;
        logic [GW-1:0] idx_g;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx_g     = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            idx_g = GW'((int'(last_grant) + i) % NPORTS);
            if (!found && i_valid[idx_g]) begin
                grant[idx_g] = 1'b1;
                grant_idx    = idx_g;
                found        = 1'b1;
            end
        end
    end

    // Acks are suppressed when full (a same-cycle pop does not free space early) and during reset.
    assign o_ack  = grant & {NPORTS{~o_fifo_full & i_rstn}};
    assign o_busy = |(i_valid & ~o_ack);
    assign wr_en  = |o_ack;
    assign rd_en  = i_read & ~o_fifo_empty;
    // Only the granted port's data is muxed; it is only stored when acked, so idle ports never reach control.
    assign wr_dat = i_data[int'(grant_idx)*WIDTH +: WIDTH];

    assign o_data       = mem[rd_ptr];
    assign o_fifo_full  = (o_count == CW'(DEPTH));
    assign o_fifo_empty = (o_count == '0);

    // Storage array; contents are not reset, stale entries are unreachable once pointers clear.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers, occupancy and arbiter history.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            last_grant <= GW'(NPORTS-1);
        end else begin
            if (wr_en) begin
                wr_ptr     <= wr_ptr + AW'(1);
                last_grant <= grant_idx;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   o_count <= o_count + CW'(1);
                2'b01:   o_count <= o_count - CW'(1);
                default: o_count <= o_count;
            endcase
        end
    end

endmodule
